ssd1306_spi_rx: RTL
===================

# ssd1306_spi_rx

SPI receiver and command decoder that models the SSD1306 end of the 4-wire SPI link (CS, D/C, SCLK, MOSI; mode 0, MSB first). It deserialises bytes, splits them into commands and display data, collects multi-byte command parameters, and tracks the GDDRAM column and page pointers. It emits one write strobe per data byte toward a frame-buffer RAM. It sits in simulation benches and on-FPGA loopback designs as the counterpart of the LCD driver.

## Interface
- No parameters.
- i_clk  in  1  system clock (27 MHz); sole clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_spi_cs  in  1  chip select, active low; asynchronous to i_clk.
- i_spi_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- i_spi_clk  in  1  SPI clock, idle low, data sampled on rising edge.
- i_spi_data  in  1  MOSI.
- o_cmd_valid  out  1  one-cycle pulse when a command and all its parameters have been received.
- o_cmd  out  8  opcode of the last completed command.
- o_wr_en  out  1  one-cycle pulse per received data byte.
- o_wr_page  out  3  page address for the o_wr_en write.
- o_wr_col  out  7  column address for the o_wr_en write.
- o_wr_data  out  8  data byte for the o_wr_en write.
- o_display_on  out  1  0xAE clears it, 0xAF sets it.
- o_contrast  out  8  value set by 0x81 pp.
- o_invert  out  1  0xA6 clears it, 0xA7 sets it.
- o_addr_mode  out  2  value set by 0x20 pp[1:0]. 0 = horizontal, 1 = vertical, 2 = page. Value 3 is treated as page mode.
- o_frame_err  out  1  one-cycle pulse when CS deasserts with a partial byte pending.

## Operation
- Input conditioning:
  - cs, dc, clk and data each pass through a 2-FF synchroniser.
  - A rising edge is detected when the synchronised clk is 1 and its previous sample was 0.
  - Edges are honoured only while the synchronised cs is 0.
- Shifter:
  - 3-bit bit counter and 8-bit shift register, MSB first.
  - The 8th edge completes a byte. dc is latched on that edge. The counter returns to 0.
- CS abort: a synchronised cs rising edge with bit counter != 0 discards the partial byte, clears the counter and pulses o_frame_err.
- Command and parameter state persists across CS toggles. The master toggles CS per byte.
- Command FSM states:
  - CMD: waiting for an opcode.
  - PARAM1, PARAM2: collecting parameters.
- Parameter counts:
  - 1 parameter: 0x81, 0x20, 0xA8, 0xD3, 0xD5, 0xD9, 0xDB, 0x8D.
  - 2 parameters: 0x21 (col start, col end), 0x22 (page start, page end).
  - All other opcodes take 0 parameters. Unknown opcodes still pulse o_cmd_valid and have no other effect.
- A data byte arriving while in PARAM1 or PARAM2 abandons the command. No o_cmd_valid is produced, the FSM returns to CMD, and the byte is processed as data.
- Command effects, applied on completion:
  - 0x21: col_start = p0[6:0], col_end = p1[6:0], col = col_start.
  - 0x22: page_start = p0[2:0], page_end = p1[2:0], page = page_start.
  - 0xB0-0xB7: page = op[2:0].
  - 0x00-0x0F: col[3:0] = op[3:0].
  - 0x10-0x17: col[6:4] = op[2:0].
- Data byte handling:
  - o_wr_en pulses with the current page and col, then the pointer advances.
  - Horizontal mode: if col == col_end, col = col_start and page advances (page_end wraps to page_start); else col + 1.
  - Vertical mode: same rule with the roles of page and col swapped.
  - Page mode: if col == col_end, col = col_start; else col + 1. page is unchanged.
- Reset values:
  - All outputs 0, except o_addr_mode = 2 and o_contrast = 0x7F.
  - col = 0, page = 0, col_start = 0, col_end = 127, page_start = 0, page_end = 7.
  - FSM in CMD, bit counter 0.

## Timing
- o_wr_en and o_cmd_valid assert exactly 3 i_clk cycles after the first i_clk edge at which raw i_spi_clk is high for the 8th bit. Each is a single-cycle pulse.
- o_wr_page, o_wr_col and o_wr_data are valid only while o_wr_en = 1.
- o_cmd and the status registers update in the same cycle as o_cmd_valid.
- SCLK high and low phases must each be ≥ 3 i_clk cycles. i_spi_cs and i_spi_dc must be stable ≥ 3 i_clk cycles before the first and after the last SCLK edge.
- A completed byte and an o_frame_err pulse never coincide.
- Reset mid-byte or mid-command discards all progress. The first complete byte after reset is decoded as an opcode.

## Test plan
- Reset check: assert i_rst for 2 cycles, then verify every output matches its reset value. Send 0xAF with dc=0: o_cmd_valid pulses once with o_cmd = 0xAF and o_display_on = 1.
- Contrast command: send 0x81, 0x40, toggling CS between bytes. Exactly one o_cmd_valid pulse occurs, after the 2nd byte, with o_cmd = 0x81 and o_contrast = 0x40.
- Horizontal fill: send 0x20, 0x00, then 129 data bytes with values 0..128. Writes land on page 0, cols 0..127, then page 1, col 0 with data 128.
- Column/page window: send 0x20 0x00, 0x21 0x10 0x12, 0x22 0x02 0x03, then 4 data bytes. Write addresses are (2,0x10), (2,0x11), (2,0x12), (3,0x10).
- Page-mode addressing: from reset, send 0xB3, 0x05, 0x12, then data 0xA5. o_wr_en pulses with page 3, col 0x25, data 0xA5.
- CS abort: deliver 5 bits of 0xFF, then raise CS. o_frame_err pulses once and no o_wr_en or o_cmd_valid occurs. A following command 0xA7 decodes correctly and sets o_invert = 1.

Source files
------------

// File: rtl/ssd1306_spi_rx.sv
// SSD1306-side 4-wire SPI receiver: deserialises mode-0 bytes, splits them
// into commands and display data, tracks GDDRAM column/page pointers and
// emits one frame-buffer write strobe per data byte.
module ssd1306_spi_rx (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_spi_cs,
    input  logic       i_spi_dc,
    input  logic       i_spi_clk,
    input  logic       i_spi_data,
    output logic       o_cmd_valid,
    output logic [7:0] o_cmd,
    output logic       o_wr_en,
    output logic [2:0] o_wr_page,
    output logic [6:0] o_wr_col,
    output logic [7:0] o_wr_data,
    output logic       o_display_on,
    output logic [7:0] o_contrast,
    output logic       o_invert,
    output logic [1:0] o_addr_mode,
    output logic       o_frame_err
);

    typedef enum logic [1:0] {
        ST_CMD    = 2'd0,
        ST_PARAM1 = 2'd1,
        ST_PARAM2 = 2'd2
    } state_t;

    // Number of parameter bytes that follow an opcode.
    function automatic logic [1:0] param_count(input logic [7:0] op);
        case (op)
            8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D: param_count = 2'd1;
            8'h21, 8'h22:                                             param_count = 2'd2;
            default:                                                  param_count = 2'd0;
        endcase
    endfunction

    logic       cs_m_r, cs_s_r, cs_d_r;
    logic       clk_m_r, clk_s_r, clk_d_r;
    logic       dc_m_r, dc_s_r;
    logic       data_m_r, data_s_r;
    logic       rise_s, cs_rise_s;

    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] byte_r;
    logic       byte_dc_r;
    logic       byte_valid_r;

    state_t     state_r, state_n;
    logic       cmd_done_s;
    logic [7:0] done_op_s;
    logic [7:0] op_r;
    logic [6:0] p0_r;

    logic [6:0] col_r, col_start_r, col_end_r;
    logic [2:0] page_r, page_start_r, page_end_r;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cs_m_r   <= 1'b1;
            cs_s_r   <= 1'b1;
            cs_d_r   <= 1'b1;
            clk_m_r  <= 1'b0;
            clk_s_r  <= 1'b0;
            clk_d_r  <= 1'b0;
            dc_m_r   <= 1'b0;
            dc_s_r   <= 1'b0;
            data_m_r <= 1'b0;
            data_s_r <= 1'b0;
        end else begin
            cs_m_r   <= i_spi_cs;
            cs_s_r   <= cs_m_r;
            cs_d_r   <= cs_s_r;
            clk_m_r  <= i_spi_clk;
            clk_s_r  <= clk_m_r;
            clk_d_r  <= clk_s_r;
            dc_m_r   <= i_spi_dc;
            dc_s_r   <= dc_m_r;
            data_m_r <= i_spi_data;
            data_s_r <= data_m_r;
        end
    end

    assign rise_s    = clk_s_r & ~clk_d_r & ~cs_s_r;
    assign cs_rise_s = cs_s_r & ~cs_d_r;

    // Bit shifter: assembles MSB-first bytes, aborts partial bytes on CS release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_r       <= 8'h00;
            byte_dc_r    <= 1'b0;
            byte_valid_r <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            o_frame_err  <= 1'b0;
            if (cs_rise_s && (bit_cnt_r != 3'd0)) begin
                bit_cnt_r   <= 3'd0;
                o_frame_err <= 1'b1;
            end else if (rise_s) begin
                shift_r   <= {shift_r[6:0], data_s_r};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_r       <= {shift_r[6:0], data_s_r};
                    byte_dc_r    <= dc_s_r;
                    byte_valid_r <= 1'b1;
                end
            end
        end
    end

    // Command FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_CMD;
        end else begin
            state_r <= state_n;
        end
    end

    // Command FSM next state; flags command completion and the finished opcode.
    always_comb begin
        state_n    = state_r;
        cmd_done_s = 1'b0;
        done_op_s  = op_r;
        if (byte_valid_r && !byte_dc_r) begin
            case (state_r)
                ST_CMD: begin
                    done_op_s = byte_r;
                    if (param_count(byte_r) == 2'd0) begin
                        cmd_done_s = 1'b1;
                    end else begin
                        state_n = ST_PARAM1;
                    end
                end
                ST_PARAM1: begin
                    if (param_count(op_r) == 2'd2) begin
                        state_n = ST_PARAM2;
                    end else begin
                        state_n    = ST_CMD;
                        cmd_done_s = 1'b1;
                    end
                end
                ST_PARAM2: begin
                    state_n    = ST_CMD;
                    cmd_done_s = 1'b1;
                end
                default: state_n = ST_CMD;
            endcase
        end else if (byte_valid_r) begin
            // Data byte abandons any half-collected command.
            state_n = ST_CMD;
        end else begin
            state_n = state_r;
        end
    end

    // Command effects, status registers, address pointers and write strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_r         <= 8'h00;
            p0_r         <= 7'd0;
            o_cmd_valid  <= 1'b0;
            o_cmd        <= 8'h00;
            o_wr_en      <= 1'b0;
            o_wr_page    <= 3'd0;
            o_wr_col     <= 7'd0;
            o_wr_data    <= 8'h00;
            o_display_on <= 1'b0;
            o_contrast   <= 8'h7F;
            o_invert     <= 1'b0;
            o_addr_mode  <= 2'd2;
            col_r        <= 7'd0;
            col_start_r  <= 7'd0;
            col_end_r    <= 7'd127;
            page_r       <= 3'd0;
            page_start_r <= 3'd0;
            page_end_r   <= 3'd7;
        end else begin
            o_cmd_valid <= 1'b0;
            o_wr_en     <= 1'b0;
            if (byte_valid_r && !byte_dc_r && (state_r == ST_CMD)) begin
                op_r <= byte_r;
            end
            if (byte_valid_r && !byte_dc_r && (state_r == ST_PARAM1)) begin
                p0_r <= byte_r[6:0];
            end
            if (cmd_done_s) begin
                o_cmd_valid <= 1'b1;
                o_cmd       <= done_op_s;
                case (done_op_s)
                    8'hAE: o_display_on <= 1'b0;
                    8'hAF: o_display_on <= 1'b1;
                    8'hA6: o_invert     <= 1'b0;
                    8'hA7: o_invert     <= 1'b1;
                    8'h81: o_contrast   <= byte_r;
                    8'h20: o_addr_mode  <= byte_r[1:0];
                    8'h21: begin
                        col_start_r <= p0_r;
                        col_end_r   <= byte_r[6:0];
                        col_r       <= p0_r;
                    end
                    8'h22: begin
                        page_start_r <= p0_r[2:0];
                        page_end_r   <= byte_r[2:0];
                        page_r       <= p0_r[2:0];
                    end
                    default: begin
                        if (done_op_s[7:3] == 5'b10110) begin
                            page_r <= done_op_s[2:0];
                        end else if (done_op_s[7:4] == 4'h0) begin
                            col_r[3:0] <= done_op_s[3:0];
                        end else if (done_op_s[7:3] == 5'b00010) begin
                            col_r[6:4] <= done_op_s[2:0];
                        end else begin
                            col_r <= col_r;
                        end
                    end
                endcase
            end else if (byte_valid_r && byte_dc_r) begin
                o_wr_en   <= 1'b1;
                o_wr_page <= page_r;
                o_wr_col  <= col_r;
                o_wr_data <= byte_r;
                case (o_addr_mode)
                    2'd0: begin
                        if (col_r == col_end_r) begin
                            col_r  <= col_start_r;
                            page_r <= (page_r == page_end_r) ? page_start_r : page_r + 3'd1;
                        end else begin
                            col_r <= col_r + 7'd1;
                        end
                    end
                    2'd1: begin
                        if (page_r == page_end_r) begin
                            page_r <= page_start_r;
                            col_r  <= (col_r == col_end_r) ? col_start_r : col_r + 7'd1;
                        end else begin
                            page_r <= page_r + 3'd1;
                        end
                    end
                    default: begin
                        col_r <= (col_r == col_end_r) ? col_start_r : col_r + 7'd1;
                    end
                endcase
            end
        end
    end

endmodule
